step_timing_sequencer: RTL and testbench

Upstream control-timing stage for the 16-output step decoder. Generates the registered 4-bit step number (Sel) and Enable that the decoder turns into one-hot T0..T15 timing pulses for the prototype processor's control unit. Supports free-run, single-step (front-panel) operation, variable instruction length, restart, halt and a retired-instruction counter.

---
 rtl/step_timing_sequencer.sv | 100 ++++++++++
 tb/tb_step_timing_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_timing_sequencer.sv
// Step-number generator feeding the 16-output step decoder (Sel/Enable).
// Handles free-run, front-panel single step, variable instruction length, restart and halt.
//
// state  | meaning
// IDLE   | waiting for Run; Sel=0, Enable=0
// ACTIVE | stepping through the instruction; Enable=1
// HALTED | frozen with Sel held; only Reset leaves
module step_timing_sequencer #(
  parameter int MAX_STEP  = 15,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic                 SingleStep,
  input  logic                 StepReq,
  input  logic [3:0]           LastStep,
  input  logic                 Restart,
  input  logic                 Halt,
  output logic [3:0]           Sel,
  output logic                 Enable,
  output logic                 InstrDone,
  output logic                 Halted,
  output logic [CNT_WIDTH-1:0] InstrCount
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  localparam logic [3:0] maxStep = 4'(MAX_STEP);

  logic [1:0]           state;
  logic [1:0]           stateNext;
  logic [3:0]           selNext;
  logic                 doneNext;
  logic [CNT_WIDTH-1:0] countNext;
  logic                 stepReqQ;
  logic                 adv;
  logic [3:0]           effLast;

  always_comb begin
    adv       = SingleStep ? (StepReq && !stepReqQ) : 1'b1;
    effLast   = (LastStep > maxStep) ? maxStep : LastStep;
    stateNext = state;
    selNext   = Sel;
    doneNext  = 1'b0;
    countNext = InstrCount;
    case (state)
      IDLE: begin
        selNext = 4'd0;
        if (Run && !Halt) stateNext = ACTIVE;
      end
      ACTIVE: begin
        if (Halt) begin
          stateNext = HALTED;
        end else if (Restart) begin
          selNext = 4'd0;
        end else if (adv) begin
          // >= so a LastStep lowered below Sel ends the instruction instead of wrapping
          if (Sel >= effLast) begin
            doneNext  = 1'b1;
            countNext = InstrCount + CNT_WIDTH'(1);
            selNext   = 4'd0;
            if (!Run) stateNext = IDLE;
          end else begin
            selNext = Sel + 4'd1;
          end
        end
      end
      HALTED: begin
        stateNext = HALTED;
      end
      default: begin
        stateNext = IDLE;
        selNext   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      Sel        <= 4'd0;
      Enable     <= 1'b0;
      InstrDone  <= 1'b0;
      Halted     <= 1'b0;
      InstrCount <= '0;
      stepReqQ   <= 1'b0;
    end else begin
      state      <= stateNext;
      Sel        <= selNext;
      Enable     <= (stateNext == ACTIVE);
      InstrDone  <= doneNext;
      Halted     <= (stateNext == HALTED);
      InstrCount <= countNext;
      stepReqQ   <= StepReq;
    end
  end

endmodule

// File: tb/tb_step_timing_sequencer.sv
// Directed bench for step_timing_sequencer: default instance (A) and a
// MAX_STEP=7 / CNT_WIDTH=4 instance (B) driven by the same inputs.
module tb_step_timing_sequencer;

  logic Clock = 1'b0;
  logic Reset, Run, SingleStep, StepReq, Restart, Halt;
  logic [3:0] LastStep;

  logic [3:0]  selA, selB;
  logic        enA, enB, doneA, doneB, haltA, haltB;
  logic [15:0] cntA;
  logic [3:0]  cntB;

  int nVec = 0;
  int nErr = 0;

  always #5 Clock = ~Clock;

  step_timing_sequencer dutA (
    .Clock(Clock), .Reset(Reset), .Run(Run), .SingleStep(SingleStep), .StepReq(StepReq),
    .LastStep(LastStep), .Restart(Restart), .Halt(Halt),
    .Sel(selA), .Enable(enA), .InstrDone(doneA), .Halted(haltA), .InstrCount(cntA)
  );

  step_timing_sequencer #(.MAX_STEP(7), .CNT_WIDTH(4)) dutB (
    .Clock(Clock), .Reset(Reset), .Run(Run), .SingleStep(SingleStep), .StepReq(StepReq),
    .LastStep(LastStep), .Restart(Restart), .Halt(Halt),
    .Sel(selB), .Enable(enB), .InstrDone(doneB), .Halted(haltB), .InstrCount(cntB)
  );

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic doReset();
    Run = 0; SingleStep = 0; StepReq = 0; Restart = 0; Halt = 0; LastStep = 4'd0;
    Reset = 1;
    #2;
    Reset = 0;
  endtask

  task automatic test_reset();
    Run = 0; SingleStep = 0; StepReq = 0; Restart = 0; Halt = 0; LastStep = 4'd0;
    Reset = 1;
    cyc();
    nVec++;
    if ({selA, enA, doneA, haltA} !== 7'd0 || cntA !== 16'd0) begin
      nErr++;
      $display("FAIL reset: sel=%0d en=%b done=%b halt=%b cnt=%0d, want all 0", selA, enA, doneA, haltA, cntA);
    end
    Reset = 0;
    Run = 1; Halt = 1;
    cyc();
    nVec++;
    if (enA !== 1'b0 || haltA !== 1'b0) begin
      nErr++; $display("FAIL idle_halt: en=%b halt=%b, want 0 0", enA, haltA);
    end
    Run = 0; Halt = 0;
  endtask

  task automatic test_free_run();
    doReset();
    LastStep = 4'd3; Run = 1;
    cyc();
    nVec++;
    if (enA !== 1'b1 || selA !== 4'd0 || doneA !== 1'b0) begin
      nErr++; $display("FAIL free_start: en=%b sel=%0d done=%b, want 1 0 0", enA, selA, doneA);
    end
    for (int k = 1; k <= 10; k++) begin
      cyc();
      nVec++;
      if (selA !== 4'(k % 4) || doneA !== (k % 4 == 0) || cntA !== 16'(k / 4) || enA !== 1'b1) begin
        nErr++;
        $display("FAIL free_run[%0d]: sel=%0d done=%b cnt=%0d en=%b, want %0d %b %0d 1",
                 k, selA, doneA, cntA, enA, k % 4, (k % 4 == 0), k / 4);
      end
    end
  endtask

  task automatic test_run_drop();
    doReset();
    LastStep = 4'd5; Run = 1;
    cyc();
    cyc();
    Run = 0;
    for (int s = 2; s <= 5; s++) begin
      cyc();
      nVec++;
      if (selA !== 4'(s) || enA !== 1'b1 || doneA !== 1'b0) begin
        nErr++; $display("FAIL run_drop_step: sel=%0d en=%b done=%b, want %0d 1 0", selA, enA, doneA, s);
      end
    end
    cyc();
    nVec++;
    if (selA !== 4'd0 || enA !== 1'b0 || doneA !== 1'b1 || cntA !== 16'd1) begin
      nErr++; $display("FAIL run_drop_end: sel=%0d en=%b done=%b cnt=%0d, want 0 0 1 1", selA, enA, doneA, cntA);
    end
    cyc();
    nVec++;
    if (selA !== 4'd0 || enA !== 1'b0 || doneA !== 1'b0 || cntA !== 16'd1) begin
      nErr++; $display("FAIL run_drop_idle: sel=%0d en=%b done=%b cnt=%0d, want 0 0 0 1", selA, enA, doneA, cntA);
    end
  endtask

  task automatic test_single_step();
    doReset();
    SingleStep = 1; LastStep = 4'd5; Run = 1;
    cyc();
    nVec++;
    if (selA !== 4'd0 || enA !== 1'b1) begin
      nErr++; $display("FAIL ss_start: sel=%0d en=%b, want 0 1", selA, enA);
    end
    cyc();
    nVec++;
    if (selA !== 4'd0) begin
      nErr++; $display("FAIL ss_no_req: sel=%0d, want 0", selA);
    end
    StepReq = 1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      nVec++;
      if (selA !== 4'd1 || enA !== 1'b1) begin
        nErr++; $display("FAIL ss_held[%0d]: sel=%0d en=%b, want 1 1", k, selA, enA);
      end
    end
    StepReq = 0;
    cyc();
    nVec++;
    if (selA !== 4'd1) begin
      nErr++; $display("FAIL ss_low: sel=%0d, want 1", selA);
    end
    StepReq = 1;
    cyc();
    nVec++;
    if (selA !== 4'd2) begin
      nErr++; $display("FAIL ss_second: sel=%0d, want 2", selA);
    end
    SingleStep = 0;
    cyc();
    nVec++;
    if (selA !== 4'd3) begin
      nErr++; $display("FAIL ss_toggle: sel=%0d, want 3", selA);
    end
  endtask

  task automatic test_restart();
    doReset();
    LastStep = 4'd10; Run = 1;
    repeat (5) cyc();
    nVec++;
    if (selA !== 4'd4) begin
      nErr++; $display("FAIL restart_pre: sel=%0d, want 4", selA);
    end
    Restart = 1;
    cyc();
    nVec++;
    if (selA !== 4'd0 || enA !== 1'b1 || doneA !== 1'b0 || cntA !== 16'd0) begin
      nErr++; $display("FAIL restart: sel=%0d en=%b done=%b cnt=%0d, want 0 1 0 0", selA, enA, doneA, cntA);
    end
    Restart = 0;
    cyc();
    nVec++;
    if (selA !== 4'd1) begin
      nErr++; $display("FAIL restart_post: sel=%0d, want 1", selA);
    end
  endtask

  task automatic test_halt();
    doReset();
    LastStep = 4'd10; Run = 1;
    repeat (7) cyc();
    Halt = 1; Restart = 1;
    cyc();
    nVec++;
    if (selA !== 4'd6 || enA !== 1'b0 || haltA !== 1'b1 || doneA !== 1'b0) begin
      nErr++; $display("FAIL halt_wins: sel=%0d en=%b halt=%b done=%b, want 6 0 1 0", selA, enA, haltA, doneA);
    end
    Halt = 0; StepReq = 1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      nVec++;
      if (selA !== 4'd6 || enA !== 1'b0 || haltA !== 1'b1) begin
        nErr++; $display("FAIL halt_hold[%0d]: sel=%0d en=%b halt=%b, want 6 0 1", k, selA, enA, haltA);
      end
      StepReq = ~StepReq;
    end
    Restart = 0;
    doReset();
    #1;
    nVec++;
    if (haltA !== 1'b0 || selA !== 4'd0) begin
      nErr++; $display("FAIL halt_exit: halt=%b sel=%0d, want 0 0", haltA, selA);
    end
  endtask

  task automatic test_clamp();
    doReset();
    LastStep = 4'd12; Run = 1;
    cyc();
    for (int s = 1; s <= 7; s++) begin
      cyc();
      nVec++;
      if (selB !== 4'(s) || doneB !== 1'b0) begin
        nErr++; $display("FAIL clamp_step: selB=%0d doneB=%b, want %0d 0", selB, doneB, s);
      end
    end
    cyc();
    nVec++;
    if (selB !== 4'd0 || doneB !== 1'b1 || cntB !== 4'd1 || selA !== 4'd8) begin
      nErr++; $display("FAIL clamp_wrap: selB=%0d doneB=%b cntB=%0d selA=%0d, want 0 1 1 8", selB, doneB, cntB, selA);
    end
    repeat (5) cyc();
    LastStep = 4'd2;
    cyc();
    nVec++;
    if (selB !== 4'd0 || doneB !== 1'b1 || cntB !== 4'd2) begin
      nErr++; $display("FAIL lower_last: selB=%0d doneB=%b cntB=%0d, want 0 1 2", selB, doneB, cntB);
    end
  endtask

  task automatic test_wrap();
    doReset();
    LastStep = 4'd0; Run = 1;
    cyc();
    for (int k = 1; k <= 16; k++) begin
      cyc();
      nVec++;
      if (selB !== 4'd0 || doneB !== 1'b1 || enB !== 1'b1 || cntB !== 4'(k % 16)) begin
        nErr++; $display("FAIL wrap[%0d]: selB=%0d doneB=%b enB=%b cntB=%0d, want 0 1 1 %0d", k, selB, doneB, enB, cntB, k % 16);
      end
    end
    nVec++;
    if (cntA !== 16'd16) begin
      nErr++; $display("FAIL wide_count: cntA=%0d, want 16", cntA);
    end
  endtask

  task automatic test_async_reset();
    doReset();
    LastStep = 4'd12; Run = 1;
    repeat (10) cyc();
    nVec++;
    if (selA !== 4'd9) begin
      nErr++; $display("FAIL async_pre: sel=%0d, want 9", selA);
    end
    #2;
    Reset = 1;
    #1;
    nVec++;
    if ({selA, enA, doneA, haltA} !== 7'd0 || cntA !== 16'd0 || {selB, enB} !== 5'd0) begin
      nErr++; $display("FAIL async_reset: sel=%0d en=%b done=%b halt=%b cnt=%0d, want all 0", selA, enA, doneA, haltA, cntA);
    end
    Run = 0;
    #1;
    Reset = 0;
    cyc();
    nVec++;
    if (enA !== 1'b0 || selA !== 4'd0) begin
      nErr++; $display("FAIL async_idle: en=%b sel=%0d, want 0 0", enA, selA);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_run_drop();
    test_single_step();
    test_restart();
    test_halt();
    test_clamp();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
